pc_redirect_ctrl: RTL
=====================

# pc_redirect_ctrl

Control-flow redirect generator for the MIPS pipeline's PC path. Consumes branch resolution from EX and jump decode from ID, computes the redirect target, and drives the select and alternate-input side of the registered PC source mux. Holds a redirect while the PC is stalled and asserts IF/ID and ID/EX flushes to squash wrong-path instructions, including the extra fetch caused by the mux's one-cycle registration.

## Interface
- FLUSH_DRAIN_CYCLES, 1: extra cycles `flush_if_id` stays high after the issue cycle (legal 0..3).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- br_valid  in  1  EX holds a resolved conditional branch this cycle.
- br_taken  in  1  branch outcome; ignored unless `br_valid`.
- br_pc  in  32  PC of the EX branch.
- br_imm  in  32  sign-extended 16-bit word offset.
- jmp_valid  in  1  ID holds a J/JAL.
- jmp_pc  in  32  PC of the ID jump.
- jmp_index  in  26  jump instruction index field.
- pc_stall  in  1  hazard unit holding the PC register.
- redirect_sel  out  1  PC mux select (1 = take `redirect_target`).
- redirect_target  out  32  PC mux alternate input.
- flush_if_id  out  1  squash IF/ID.
- flush_id_ex  out  1  squash ID/EX.
- pending  out  1  redirect captured, not yet issued.

## Operation
- Request: `br_valid & br_taken` (branch) or `jmp_valid` (jump). Not-taken branches produce no action.
- Branch target = br_pc + 4 + (br_imm << 2), modulo 2^32. Jump target = {(jmp_pc + 4)[31:28], jmp_index, 2'b00}.
- Both requests in the same cycle: the branch wins (it is older); the jump is discarded as wrong-path.
- FSM states: IDLE, HOLD, ISSUE, DRAIN.
  - IDLE: a request with `pc_stall`=0 goes to ISSUE; with `pc_stall`=1 it goes to HOLD and captures the target.
  - HOLD: `pending`=1; waits for `pc_stall`=0 at a sampling edge, then goes to ISSUE with the held target.
  - ISSUE: lasts one cycle; `redirect_sel`=1, `redirect_target` valid, `flush_if_id`=`flush_id_ex`=1. Next state is DRAIN if FLUSH_DRAIN_CYCLES>0, else IDLE.
  - DRAIN: `flush_if_id`=1 for FLUSH_DRAIN_CYCLES cycles via a down-counter, then IDLE.
- Requests arriving in HOLD, ISSUE or DRAIN are ignored; they are wrong-path by construction.
- `redirect_target` holds its last value outside ISSUE. Only `redirect_sel` qualifies it.

## Timing
- All outputs are registered. A request sampled at edge E with `pc_stall`=0 produces ISSUE outputs in the cycle after E. The PC mux latches the target at the next edge.
- `pc_stall` rising while in ISSUE does not cancel the issue. The hazard unit must not stall the cycle a redirect is presented.
- Reset (`rst_n`=0 at an edge), including mid-HOLD or mid-DRAIN, has the following effect:
  - state goes to IDLE and the drain counter to 0;
  - `redirect_sel`, `flush_if_id`, `flush_id_ex` and `pending` go to 0;
  - `redirect_target` and the held target go to 32'h0.
- Request inputs sampled while `rst_n`=0 are dropped.

## Configuration
- PC_REDIRECT_COUNT_EN defined: adds output `redirect_count` [31:0], reset 0. It increments by 1 in each ISSUE cycle and wraps from 32'hFFFFFFFF to 0.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Package `pc_redirect_pkg` holds:
  - the state enum (IDLE/HOLD/ISSUE/DRAIN);
  - constant PC_INCR = 32'd4;
  - the width constant for the drain counter.
- Sub-module `pc_target_calc` is combinational. It takes the branch and jump fields plus the select and returns the 32-bit target. The FSM and registers stay in `pc_redirect_ctrl`.

## Test plan
- Branch taken: br_pc=0x00400010, br_imm=0x00000003, pc_stall=0 → next cycle redirect_sel=1 and target=0x00400020, both flushes=1; one DRAIN cycle with only flush_if_id=1; then IDLE.
- Backward branch plus wrap:
  - br_pc=0x00400010, br_imm=0xFFFFFFFC → target 0x00400004;
  - br_pc=0xFFFFFFFC, br_imm=0 → target 0x00000000.
- Jump versus branch in the same cycle: jmp_pc=0x00400010, jmp_index=0x0100008 together with a taken branch to 0x00400100 → only 0x00400100 is issued. The jump alone issues 0x00400020.
- Stall hold: taken branch with pc_stall=1 for 3 cycles → pending=1 for 3 cycles and no redirect_sel. On release, ISSUE carries the captured target. A second request during HOLD is ignored.
- Reset mid-HOLD: rst_n=0 for one edge while pending → all outputs 0, and no redirect issues after release.
- Config and parameter: with PC_REDIRECT_COUNT_EN, three issued redirects → redirect_count=3. With FLUSH_DRAIN_CYCLES=0 → flush_if_id high for exactly one cycle.

Source files
------------

// File: rtl/pc_redirect_pkg.sv
// Shared types and constants for the PC redirect controller.
// Optional redirect counter is enabled by PC_REDIRECT_COUNT_EN.
package pc_redirect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    ISSUE,
    DRAIN
  } state_t;

  localparam logic [31:0] PC_INCR = 32'd4;
  localparam int          DRAIN_W = 2;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target: taken-branch or J/JAL target,
// chosen by sel_br (branch has priority upstream).
module pc_target_calc
  import pc_redirect_pkg::*;
(
  input  logic        sel_br,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm,
  input  logic [31:0] jmp_pc,
  input  logic [25:0] jmp_index,
  output logic [31:0] target
);

  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] jmp_nxt;
  logic [31:0] jmp_tgt;

  assign br_off  = br_imm << 2;
  assign br_tgt  = br_pc + PC_INCR + br_off;
  assign jmp_nxt = jmp_pc + PC_INCR;
  assign jmp_tgt = (jmp_nxt & 32'hF000_0000)
                 | {4'b0, jmp_index, 2'b00};
  assign target  = sel_br ? br_tgt : jmp_tgt;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect FSM: holds redirects across PC stalls, issues them
// and flushes wrong-path stages. PC_REDIRECT_COUNT_EN adds a counter.
module pc_redirect_ctrl
  import pc_redirect_pkg::*;
#(
  parameter int FLUSH_DRAIN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_pc,
  input  logic [25:0] jmp_index,
  input  logic        pc_stall,
  output logic        redirect_sel,
  output logic [31:0] redirect_target,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        pending
`ifdef PC_REDIRECT_COUNT_EN
  ,
  output logic [31:0] redirect_count
`endif
);

  localparam bit HAS_DRAIN = FLUSH_DRAIN_CYCLES > 0;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
    DRAIN_W'(HAS_DRAIN ? FLUSH_DRAIN_CYCLES - 1 : 0);

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [31:0]        held;
  logic               br_req;
  logic               req;
  logic [31:0]        calc_tgt;

  assign br_req = br_valid & br_taken;
  assign req    = br_req | jmp_valid;

  pc_target_calc u_calc (
    .sel_br    (br_req),
    .br_pc     (br_pc),
    .br_imm    (br_imm),
    .jmp_pc    (jmp_pc),
    .jmp_index (jmp_index),
    .target    (calc_tgt)
  );

  // Redirect sequencing with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      drain_cnt       <= '0;
      held            <= '0;
      redirect_target <= '0;
      redirect_sel    <= 1'b0;
      flush_if_id     <= 1'b0;
      flush_id_ex     <= 1'b0;
      pending         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (pc_stall) begin
              state   <= HOLD;
              held    <= calc_tgt;
              pending <= 1'b1;
            end else begin
              state           <= ISSUE;
              redirect_target <= calc_tgt;
              redirect_sel    <= 1'b1;
              flush_if_id     <= 1'b1;
              flush_id_ex     <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!pc_stall) begin
            state           <= ISSUE;
            redirect_target <= held;
            redirect_sel    <= 1'b1;
            flush_if_id     <= 1'b1;
            flush_id_ex     <= 1'b1;
            pending         <= 1'b0;
          end
        end
        ISSUE: begin
          redirect_sel <= 1'b0;
          flush_id_ex  <= 1'b0;
          if (HAS_DRAIN) begin
            state       <= DRAIN;
            drain_cnt   <= DRAIN_LOAD;
            flush_if_id <= 1'b1;
          end else begin
            state       <= IDLE;
            flush_if_id <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state       <= IDLE;
            flush_if_id <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PC_REDIRECT_COUNT_EN
  // Count issued redirects, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_count <= '0;
    end else if (state == ISSUE) begin
      redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule
